// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one uart transmitter between NUM_REQ byte sources.
// Optional stalled-owner timeout: define UART_ARB_LOCK_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int PTR_W        = 2,
    parameter int BUSY_WAIT    = 4,
    parameter int LOCK_TIMEOUT = 25000000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 active,
    output logic                 lock_drop
);

    localparam int BW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, HOLD} state_t;

    state_t             state, state_nx;
    logic [PTR_W-1:0]   rr_ptr, owner, win, sel, nxt_ptr;
    logic [BW-1:0]      bcnt;
    logic               last_q, hit, xfer, done, drop, rel;
    logic [NUM_REQ-1:0] ready_c;

`ifdef UART_ARB_LOCK_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    logic [TW-1:0] tocnt;
`endif

    // Descending scan so the valid index closest to rr_ptr is the last one written.
    always_comb begin
        int idx;
        win = '0;
        hit = 1'b0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                win = PTR_W'(idx);
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ready_c  = '0;
        xfer     = 1'b0;
        sel      = owner;
        done     = 1'b0;
        drop     = 1'b0;
        case (state)
            IDLE: if (!tx_busy && hit) begin
                ready_c[win] = 1'b1;
                xfer         = 1'b1;
                sel          = win;
                state_nx     = START;
            end
            START:   state_nx = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy)                          state_nx = WAIT_LO;
                else if (bcnt == BW'(BUSY_WAIT - 1))  done     = 1'b1;
            end
            WAIT_LO: if (!tx_busy) done = 1'b1;
            HOLD: begin
                ready_c[owner] = 1'b1;
                if (req_valid[owner]) begin
                    xfer     = 1'b1;
                    state_nx = START;
                end
`ifdef UART_ARB_LOCK_TIMEOUT_EN
                else if (tocnt == TW'(LOCK_TIMEOUT - 1)) begin
                    drop     = 1'b1;
                    state_nx = IDLE;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
        if (done) state_nx = last_q ? IDLE : HOLD;
    end

    assign rel       = (done && last_q) || drop;
    assign nxt_ptr   = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    // Keep readies low while reset is held, even though the state already reads IDLE.
    assign req_ready = RESET ? '0 : ready_c;
    assign tx_start  = (state == START);
    assign active    = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            tx_data <= 8'h00;
            last_q  <= 1'b0;
            grant   <= '0;
            bcnt    <= '0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                tx_data <= req_data[int'(sel)*8 +: 8];
                last_q  <= req_last[sel];
                owner   <= sel;
                grant   <= NUM_REQ'(1) << sel;
            end
            if (rel) begin
                grant  <= '0;
                rr_ptr <= nxt_ptr;
            end
            if (state == START)        bcnt <= '0;
            else if (state == WAIT_HI) bcnt <= bcnt + 1'b1;
        end
    end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
    // Counts consecutive idle HOLD cycles; any transfer or state exit restarts it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tocnt     <= '0;
            lock_drop <= 1'b0;
        end else begin
            lock_drop <= drop;
            if (state == HOLD && !req_valid[owner] && !drop) tocnt <= tocnt + 1'b1;
            else                                             tocnt <= '0;
        end
    end
`else
    assign lock_drop = 1'b0;
`endif

endmodule
